// File: rtl/step_pulse_gen_pkg.sv
// Shared definitions for the step/direction generator: register map, bit
// positions, FSM encoding and the interrupt reduction helper.
package step_pulse_gen_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_HALF     = 3'd1;
    localparam logic [2:0] ADDR_TOTAL    = 3'd2;
    localparam logic [2:0] ADDR_DONE_CNT = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_EN     = 2;
    localparam int CTRL_ABORT  = 3;
    localparam int CTRL_LIM_EN = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_LIM  = 2;
    localparam int STAT_RAW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } step_state_e;

    // flags = {lim_hit, done}, en = IRQ_EN[1:0]
    function automatic logic irq_level(input logic [1:0] flags, input logic [1:0] en);
        return |(flags & en);
    endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Avalon-MM slave bus of the step generator, word addressed, read latency 1.
interface step_pulse_gen_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        avs_address;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic              avs_read;
    logic [DATA_W-1:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/step_half_timer.sv
// Loadable down-counter timing SETUP/HIGH/LOW phases; expire flags the last
// cycle of a loaded interval, so a load of N yields N cycles per phase.
module step_half_timer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    output logic              expire
);

    logic [DATA_W-1:0] cnt_r;

    // Count down to zero; a load always takes priority over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {DATA_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {DATA_W{1'b0}}) begin
            cnt_r <= cnt_r - DATA_W'(1);
        end
    end

    assign expire = (cnt_r == DATA_W'(1));

endmodule

// File: rtl/step_pulse_gen.sv
// Avalon-MM programmable STEP/DIR pulse generator with home-limit stop,
// abort, sticky done/lim_hit status and a level interrupt.
module step_pulse_gen
    import step_pulse_gen_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MIN_HALF = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    step_pulse_gen_if.slave   bus,
    input  logic              limit_signal,
    output logic              pulse,
    output logic              dirction,
    output logic              coe_enable,
    output logic              irq
);

    step_state_e       state_r;
    logic              pulse_r;
    logic              dir_out_r;
    logic [DATA_W-1:0] half_r;
    logic [DATA_W-1:0] total_r;
    logic [DATA_W-1:0] half_lat_r;
    logic [DATA_W-1:0] total_lat_r;
    logic [DATA_W-1:0] done_cnt_r;
    logic [DATA_W-1:0] rdata_r;
    logic              ctrl_dir_r;
    logic              ctrl_en_r;
    logic              ctrl_lim_en_r;
    logic              done_r;
    logic              lim_r;
    logic              irq_r;
    logic [1:0]        irq_en_r;

    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] half_eff_s;
    logic [DATA_W-1:0] tmr_load_val_s;
    logic [DATA_W-1:0] rdata_s;
    logic [1:0]        irq_en_nxt_s;
    logic wr_ctrl_s, wr_half_s, wr_total_s, wr_status_s, wr_irq_en_s;
    logic start_s, abort_s, busy_s;
    logic idle_lim_s, idle_zero_s, run_start_s;
    logic lim_stop_s, stop_s, last_step_s;
    logic done_set_s, lim_set_s, done_nxt_s, lim_nxt_s;
    logic tmr_load_s, tmr_expire_s;

    step_half_timer #(.DATA_W(DATA_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_load_val_s),
        .expire   (tmr_expire_s)
    );

    // Bus decode, move start/stop decisions and next values of the sticky flags.
    always_comb begin
        wdata_s     = bus.avs_writedata;
        wr_ctrl_s   = bus.avs_write && (bus.avs_address == ADDR_CTRL);
        wr_half_s   = bus.avs_write && (bus.avs_address == ADDR_HALF);
        wr_total_s  = bus.avs_write && (bus.avs_address == ADDR_TOTAL);
        wr_status_s = bus.avs_write && (bus.avs_address == ADDR_STATUS);
        wr_irq_en_s = bus.avs_write && (bus.avs_address == ADDR_IRQ_EN);

        // Abort in the same write as start suppresses the start entirely.
        start_s = wr_ctrl_s && wdata_s[CTRL_START] && !wdata_s[CTRL_ABORT];
        abort_s = wr_ctrl_s && wdata_s[CTRL_ABORT];
        busy_s  = (state_r != ST_IDLE);

        half_eff_s = (half_r < DATA_W'(MIN_HALF)) ? DATA_W'(MIN_HALF) : half_r;

        // The lim check at start uses the dir/lim_stop_en carried by the same write.
        idle_lim_s  = !busy_s && start_s && wdata_s[CTRL_LIM_EN] && !wdata_s[CTRL_DIR]
                      && limit_signal;
        idle_zero_s = !busy_s && start_s && !idle_lim_s && (total_r == {DATA_W{1'b0}});
        run_start_s = !busy_s && start_s && !idle_lim_s && (total_r != {DATA_W{1'b0}});

        lim_stop_s  = busy_s && ctrl_lim_en_r && !dir_out_r && limit_signal;
        stop_s      = lim_stop_s || (busy_s && abort_s);
        last_step_s = (done_cnt_r == total_lat_r);

        done_set_s = idle_zero_s
                     || ((state_r == ST_LOW) && tmr_expire_s && !stop_s && last_step_s);
        lim_set_s  = idle_lim_s || lim_stop_s;

        if (run_start_s) begin
            tmr_load_s     = 1'b1;
            tmr_load_val_s = half_eff_s;
        end else if (busy_s && !stop_s && tmr_expire_s
                     && !((state_r == ST_LOW) && last_step_s)) begin
            tmr_load_s     = 1'b1;
            tmr_load_val_s = half_lat_r;
        end else begin
            tmr_load_s     = 1'b0;
            tmr_load_val_s = half_lat_r;
        end

        done_nxt_s = done_set_s || (done_r && !(wr_status_s && wdata_s[STAT_DONE]));
        lim_nxt_s  = lim_set_s  || (lim_r  && !(wr_status_s && wdata_s[STAT_LIM]));

        if (wr_irq_en_s) begin
            irq_en_nxt_s = wdata_s[1:0];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end

        rdata_s = {DATA_W{1'b0}};
        case (bus.avs_address)
            ADDR_CTRL: begin
                rdata_s[CTRL_DIR]    = ctrl_dir_r;
                rdata_s[CTRL_EN]     = ctrl_en_r;
                rdata_s[CTRL_LIM_EN] = ctrl_lim_en_r;
            end
            ADDR_HALF:     rdata_s = half_r;
            ADDR_TOTAL:    rdata_s = total_r;
            ADDR_DONE_CNT: rdata_s = done_cnt_r;
            ADDR_STATUS: begin
                rdata_s[STAT_BUSY] = busy_s;
                rdata_s[STAT_DONE] = done_r;
                rdata_s[STAT_LIM]  = lim_r;
                rdata_s[STAT_RAW]  = limit_signal;
            end
            ADDR_IRQ_EN:   rdata_s[1:0] = irq_en_r;
            default:       rdata_s = {DATA_W{1'b0}};
        endcase
    end

    // Programmable registers, sticky status, interrupt and registered read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_dir_r    <= 1'b0;
            ctrl_en_r     <= 1'b0;
            ctrl_lim_en_r <= 1'b0;
            half_r        <= DATA_W'(MIN_HALF);
            total_r       <= {DATA_W{1'b0}};
            irq_en_r      <= 2'b00;
            done_r        <= 1'b0;
            lim_r         <= 1'b0;
            irq_r         <= 1'b0;
            rdata_r       <= {DATA_W{1'b0}};
        end else begin
            if (wr_ctrl_s) begin
                ctrl_dir_r    <= wdata_s[CTRL_DIR];
                ctrl_en_r     <= wdata_s[CTRL_EN];
                ctrl_lim_en_r <= wdata_s[CTRL_LIM_EN];
            end
            if (wr_half_s) begin
                half_r <= wdata_s;
            end
            if (wr_total_s) begin
                total_r <= wdata_s;
            end
            irq_en_r <= irq_en_nxt_s;
            done_r   <= done_nxt_s;
            lim_r    <= lim_nxt_s;
            // Built from next-state values so irq tracks STATUS without a lag cycle.
            irq_r    <= irq_level({lim_nxt_s, done_nxt_s}, irq_en_nxt_s);
            if (bus.avs_read) begin
                rdata_r <= rdata_s;
            end
        end
    end

    // Move sequencer: SETUP -> (HIGH -> LOW)*TOTAL, with limit/abort early exit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pulse_r     <= 1'b0;
            dir_out_r   <= 1'b0;
            half_lat_r  <= {DATA_W{1'b0}};
            total_lat_r <= {DATA_W{1'b0}};
            done_cnt_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pulse_r <= 1'b0;
                    if (run_start_s) begin
                        dir_out_r   <= wdata_s[CTRL_DIR];
                        half_lat_r  <= half_eff_s;
                        total_lat_r <= total_r;
                        done_cnt_r  <= {DATA_W{1'b0}};
                        state_r     <= ST_SETUP;
                    end else if (idle_zero_s) begin
                        done_cnt_r <= {DATA_W{1'b0}};
                    end
                end
                ST_SETUP: begin
                    if (stop_s) begin
                        state_r <= ST_IDLE;
                        pulse_r <= 1'b0;
                    end else if (tmr_expire_s) begin
                        state_r <= ST_HIGH;
                        pulse_r <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (stop_s) begin
                        state_r <= ST_IDLE;
                        pulse_r <= 1'b0;
                    end else if (tmr_expire_s) begin
                        state_r    <= ST_LOW;
                        pulse_r    <= 1'b0;
                        done_cnt_r <= done_cnt_r + DATA_W'(1);
                    end
                end
                ST_LOW: begin
                    if (stop_s) begin
                        state_r <= ST_IDLE;
                        pulse_r <= 1'b0;
                    end else if (tmr_expire_s) begin
                        if (last_step_s) begin
                            state_r <= ST_IDLE;
                            pulse_r <= 1'b0;
                        end else begin
                            state_r <= ST_HIGH;
                            pulse_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    pulse_r <= 1'b0;
                end
            endcase
        end
    end

    assign pulse            = pulse_r;
    assign dirction         = dir_out_r;
    assign coe_enable       = ctrl_en_r;
    assign irq              = irq_r;
    assign bus.avs_readdata = rdata_r;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: timing, limit/abort stops, IRQ, read latency, reset.
module tb_step_pulse_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic limit_signal;
    logic pulse, dirction, coe_enable, irq;
    int   checks = 0;
    int   errors = 0;
    int   rises, highs, first_rise, second_rise;
    logic [31:0] rd_v;

    step_pulse_gen_if #(.DATA_W(32)) bus_if ();

    step_pulse_gen #(.DATA_W(32), .MIN_HALF(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if.slave),
        .limit_signal (limit_signal),
        .pulse        (pulse),
        .dirction     (dirction),
        .coe_enable   (coe_enable),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus_if.avs_address   = a;
        bus_if.avs_writedata = d;
        bus_if.avs_write     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.avs_write     = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(posedge clk);
        #1;
        bus_if.avs_address = a;
        bus_if.avs_read    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.avs_read    = 1'b0;
        check(tag, bus_if.avs_readdata, exp);
    endtask

    // Samples pulse on n falling edges; cycle 1 is the first cycle after the call.
    task automatic watch(input int n, output int r, output int h, output int f, output int s);
        logic prev;
        prev = 1'b0;
        r = 0; h = 0; f = 0; s = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (pulse && !prev) begin
                r++;
                if (f == 0) f = k;
                else if (s == 0) s = k;
            end
            if (pulse) h++;
            prev = pulse;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        limit_signal = 1'b0;
        bus_if.avs_address = 3'd0;
        bus_if.avs_write = 1'b0;
        bus_if.avs_writedata = 32'd0;
        bus_if.avs_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_pulse", {31'd0, pulse}, 32'd0);
        check("rst_dir", {31'd0, dirction}, 32'd0);
        check("rst_en", {31'd0, coe_enable}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", bus_if.avs_readdata, 32'd0);
        rd_chk("rst_half", 3'd1, 32'd2);
        rd_chk("rst_status", 3'd4, 32'd0);

        // T1: HALF=5, TOTAL=3, dir=1
        wr(3'd1, 32'd5);
        wr(3'd2, 32'd3);
        wr(3'd0, 32'h07);
        check("t1_dir", {31'd0, dirction}, 32'd1);
        check("t1_en", {31'd0, coe_enable}, 32'd1);
        watch(45, rises, highs, first_rise, second_rise);
        check("t1_rises", rises, 32'd3);
        check("t1_highs", highs, 32'd15);
        check("t1_first_rise", first_rise, 32'd6);
        check("t1_second_rise", second_rise, 32'd16);
        rd_chk("t1_done_cnt", 3'd3, 32'd3);
        rd_chk("t1_status", 3'd4, 32'h2);
        wr(3'd4, 32'h2);

        // T2: HALF=0 clamps to 2; TOTAL=0 start
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd2);
        wr(3'd0, 32'h07);
        watch(20, rises, highs, first_rise, second_rise);
        check("t2_rises", rises, 32'd2);
        check("t2_highs", highs, 32'd4);
        check("t2_first_rise", first_rise, 32'd3);
        check("t2_second_rise", second_rise, 32'd7);
        rd_chk("t2_half_raw", 3'd1, 32'd0);
        rd_chk("t2_done_cnt", 3'd3, 32'd2);
        wr(3'd4, 32'h2);
        wr(3'd5, 32'h1);
        wr(3'd2, 32'd0);
        check("t2_irq_before", {31'd0, irq}, 32'd0);
        wr(3'd0, 32'h07);
        check("t2_zero_done_next", {31'd0, irq}, 32'd1);
        watch(10, rises, highs, first_rise, second_rise);
        check("t2_zero_no_pulse", rises, 32'd0);
        rd_chk("t2_zero_status", 3'd4, 32'h2);
        wr(3'd5, 32'h0);
        wr(3'd4, 32'h2);

        // T3: limit during third HIGH toward home
        wr(3'd1, 32'd4);
        wr(3'd2, 32'd100);
        wr(3'd0, 32'h15);
        repeat (22) @(posedge clk);
        #1 limit_signal = 1'b1;
        @(negedge clk);
        check("t3_pulse_high", {31'd0, pulse}, 32'd1);
        @(negedge clk);
        check("t3_pulse_drop", {31'd0, pulse}, 32'd0);
        rd_chk("t3_done_cnt", 3'd3, 32'd2);
        rd_chk("t3_status", 3'd4, 32'hC);
        limit_signal = 1'b0;
        wr(3'd4, 32'h4);
        rd_chk("t3_status_clr", 3'd4, 32'h0);
        limit_signal = 1'b1;
        wr(3'd0, 32'h17);
        check("t3_away_dir", {31'd0, dirction}, 32'd1);
        repeat (810) @(posedge clk);
        rd_chk("t3_away_done_cnt", 3'd3, 32'd100);
        rd_chk("t3_away_status", 3'd4, 32'hA);
        limit_signal = 1'b0;
        wr(3'd4, 32'h6);

        // T4: abort mid-LOW of step 7, then start+abort together
        wr(3'd2, 32'd20);
        wr(3'd0, 32'h07);
        repeat (56) @(posedge clk);
        wr(3'd0, 32'h0E);
        check("t4_pulse", {31'd0, pulse}, 32'd0);
        rd_chk("t4_done_cnt", 3'd3, 32'd7);
        rd_chk("t4_status", 3'd4, 32'h0);
        watch(12, rises, highs, first_rise, second_rise);
        check("t4_no_motion", rises, 32'd0);
        wr(3'd0, 32'h0F);
        watch(12, rises, highs, first_rise, second_rise);
        check("t4_start_abort", rises, 32'd0);
        rd_chk("t4_sa_status", 3'd4, 32'h0);
        rd_chk("t4_sa_done_cnt", 3'd3, 32'd7);

        // T5: done IRQ, W1C, read latency, unmapped, lim_hit IRQ
        wr(3'd5, 32'h1);
        wr(3'd1, 32'd2);
        wr(3'd2, 32'd1);
        wr(3'd0, 32'h07);
        check("t5_irq_busy", {31'd0, irq}, 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t5_irq_done", {31'd0, irq}, 32'd1);
        rd_chk("t5_status", 3'd4, 32'h2);
        wr(3'd4, 32'h2);
        check("t5_irq_w1c", {31'd0, irq}, 32'd0);
        rd_chk("t5_total", 3'd2, 32'd1);
        @(posedge clk);
        #1;
        bus_if.avs_address = 3'd1;
        bus_if.avs_read = 1'b1;
        @(negedge clk);
        check("t5_rd_lat_before", bus_if.avs_readdata, 32'd1);
        @(posedge clk);
        #1 bus_if.avs_read = 1'b0;
        check("t5_rd_lat_after", bus_if.avs_readdata, 32'd2);
        rd_chk("t5_unmapped", 3'd7, 32'd0);
        wr(3'd5, 32'h2);
        limit_signal = 1'b1;
        wr(3'd0, 32'h15);
        check("t5_irq_lim", {31'd0, irq}, 32'd1);
        rd_chk("t5_lim_status", 3'd4, 32'hC);
        limit_signal = 1'b0;
        wr(3'd4, 32'h4);
        check("t5_irq_lim_clr", {31'd0, irq}, 32'd0);

        // T6: reset during HIGH, then start while busy
        wr(3'd5, 32'h3);
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h07);
        check("t6_irq_pre", {31'd0, irq}, 32'd1);
        wr(3'd1, 32'd3);
        wr(3'd2, 32'd10);
        wr(3'd0, 32'h17);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_pulse_high", {31'd0, pulse}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t6_pulse", {31'd0, pulse}, 32'd0);
        check("t6_dir", {31'd0, dirction}, 32'd0);
        check("t6_en", {31'd0, coe_enable}, 32'd0);
        check("t6_irq", {31'd0, irq}, 32'd0);
        check("t6_rdata", bus_if.avs_readdata, 32'd0);
        rd_chk("t6_ctrl", 3'd0, 32'd0);
        rd_chk("t6_half", 3'd1, 32'd2);
        rd_chk("t6_total", 3'd2, 32'd0);
        rd_chk("t6_done_cnt", 3'd3, 32'd0);
        rd_chk("t6_status", 3'd4, 32'd0);
        rd_chk("t6_irq_en", 3'd5, 32'd0);
        wr(3'd1, 32'd4);
        wr(3'd2, 32'd3);
        wr(3'd0, 32'h07);
        repeat (8) @(posedge clk);
        wr(3'd2, 32'd50);
        wr(3'd0, 32'h05);
        check("t6_busy_dir", {31'd0, dirction}, 32'd1);
        rd_chk("t6_busy_status", 3'd4, 32'h1);
        repeat (40) @(posedge clk);
        rd_chk("t6_busy_done_cnt", 3'd3, 32'd3);
        rd_chk("t6_busy_end_status", 3'd4, 32'h2);
        rd_chk("t6_busy_ctrl", 3'd0, 32'h4);
        rd_v = 32'd0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
